// File: rtl/rep3_serial_tx.sv
// Triple-repetition serial transmitter: shifts a parallel word out MSB first, each bit on three cycles.
// Optional even-parity triplet appended after the LSB when REP3_PARITY_EN is defined.
module rep3_serial_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inj_en,
    input  logic [1:0]        inj_sel,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_first,
    output logic              tx_last
);

`ifdef REP3_PARITY_EN
    localparam int FRAME_BITS = DATA_W + 1;
`else
    localparam int FRAME_BITS = DATA_W;
`endif
    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

`ifdef REP3_PARITY_EN
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_W-1:0] d);
`ifdef REP3_PARITY_EN
        return {d, even_parity(d)};
`else
        return d;
`endif
    endfunction

    state_t                state_r, state_s;
    logic [FRAME_BITS-1:0] shift_r, shift_s;
    logic [1:0]            rep_r, rep_s;
    logic [BW-1:0]         bit_r, bit_s;
    logic                  inj_act_r, inj_act_s;
    logic [1:0]            inj_sel_r, inj_sel_s;
    logic                  accept_s;
    logic                  valid_s, first_s, last_s, sym_s, ready_s;

    // Next-state and next-output computation; outputs are registered from these values.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        rep_s     = rep_r;
        bit_s     = bit_r;
        inj_act_s = inj_act_r;
        inj_sel_s = inj_sel_r;
        accept_s  = in_valid && in_ready;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (tx_last) begin
                    if (accept_s) begin
                        state_s = SEND;
                    end else begin
                        state_s = IDLE;
                        rep_s   = 2'd0;
                        bit_s   = {BW{1'b0}};
                        shift_s = {FRAME_BITS{1'b0}};
                    end
                end else if (rep_r == 2'd2) begin
                    rep_s   = 2'd0;
                    bit_s   = bit_r + BW'(1);
                    shift_s = {shift_r[FRAME_BITS-2:0], 1'b0};
                end else begin
                    rep_s = rep_r + 2'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Acceptance overrides the stepping above, both from IDLE and on the last symbol.
        if (accept_s) begin
            shift_s   = build_frame(in_data);
            rep_s     = 2'd0;
            bit_s     = {BW{1'b0}};
            inj_act_s = inj_en && (inj_sel != 2'd3);
            inj_sel_s = inj_sel;
        end else begin
            inj_act_s = inj_act_s;
        end

        valid_s = (state_s == SEND);
        first_s = valid_s && (rep_s == 2'd0) && (bit_s == {BW{1'b0}});
        last_s  = valid_s && (rep_s == 2'd2) && (bit_s == LAST_BIT);
        sym_s   = valid_s && (shift_s[FRAME_BITS-1] ^ (inj_act_s && (inj_sel_s == rep_s)));
        ready_s = (state_s == IDLE) || last_s;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            shift_r   <= {FRAME_BITS{1'b0}};
            rep_r     <= 2'd0;
            bit_r     <= {BW{1'b0}};
            inj_act_r <= 1'b0;
            inj_sel_r <= 2'd0;
            tx_bit    <= 1'b0;
            tx_valid  <= 1'b0;
            tx_first  <= 1'b0;
            tx_last   <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            rep_r     <= rep_s;
            bit_r     <= bit_s;
            inj_act_r <= inj_act_s;
            inj_sel_r <= inj_sel_s;
            tx_bit    <= sym_s;
            tx_valid  <= valid_s;
            tx_first  <= first_s;
            tx_last   <= last_s;
            in_ready  <= ready_s;
        end
    end

endmodule

// File: tb/tb_rep3_serial_tx.sv
// Scoreboard bench for rep3_serial_tx: expected symbols are queued at hand-off and checked as they appear.
module tb_rep3_serial_tx;

    localparam int DW = 8;
`ifdef REP3_PARITY_EN
    localparam int FB = DW + 1;
`else
    localparam int FB = DW;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          inj_en = 1'b0;
    logic [1:0]    inj_sel = 2'd0;
    logic          tx_bit, tx_valid, tx_first, tx_last;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    logic [2:0] exp_q[$];

    rep3_serial_tx #(.DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .inj_en(inj_en), .inj_sel(inj_sel),
        .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_first(tx_first), .tx_last(tx_last)
    );

    always #5 clk = ~clk;

    // Output monitor: every valid symbol must match the head of the queue; pending symbols imply tx_valid.
    always @(negedge clk) begin
        if (mon_en) begin
            if (tx_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_symbol got bit/first/last=%b%b%b, required no symbol",
                             tx_bit, tx_first, tx_last);
                end else begin
                    logic [2:0] e;
                    e = exp_q.pop_front();
                    if ({tx_bit, tx_first, tx_last} !== e) begin
                        failures++;
                        $display("FAIL symbol at %0t got bit/first/last=%b%b%b, required %b",
                                 $time, tx_bit, tx_first, tx_last, e);
                    end
                end
            end else if (exp_q.size() != 0) begin
                checks++;
                failures++;
                $display("FAIL tx_valid_gap at %0t got tx_valid=%b, required 1 (%0d pending)",
                         $time, tx_valid, exp_q.size());
            end
        end
    end

    task automatic push_frame(input logic [DW-1:0] d, input logic ie, input logic [1:0] s);
        logic [FB-1:0] f;
        int ones;
        logic b;
        ones = 0;
        for (int i = 0; i < DW; i++) ones += int'(d[i]);
`ifdef REP3_PARITY_EN
        f = {d, ((ones % 2) == 1)};
`else
        f = d;
`endif
        for (int bi = FB - 1; bi >= 0; bi--) begin
            for (int r = 0; r < 3; r++) begin
                b = f[bi] ^ (ie && (s != 2'd3) && (int'(s) == r));
                exp_q.push_back({b, (bi == FB - 1) && (r == 0), (bi == 0) && (r == 2)});
            end
        end
    endtask

    task automatic offer(input logic [DW-1:0] d, input logic ie, input logic [1:0] s);
        int t;
        t = 0;
        @(negedge clk); #1;
        in_valid = 1'b1; in_data = d; inj_en = ie; inj_sel = s;
        while (in_ready !== 1'b1 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        if (t >= 200) begin
            checks++; failures++;
            $display("FAIL accept_timeout got in_ready=%b, required 1 within 200 cycles", in_ready);
        end else begin
            push_frame(d, ie, s);
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk); #1;
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got %0d pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk); #1;
        checks++;
        if (tx_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_idle got tx_valid=%b in_ready=%b, required 0 1", name, tx_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({tx_bit, tx_valid, tx_first, tx_last, in_ready} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_outputs got %b, required 00000",
                     {tx_bit, tx_valid, tx_first, tx_last, in_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got %b, required 1", in_ready);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        offer(8'hA5, 1'b0, 2'd0);
        drain("basic_a5");
    endtask

    task automatic test_back_to_back();
        offer(8'hFF, 1'b0, 2'd0);
        offer(8'h00, 1'b0, 2'd0);
        drain("b2b");
    endtask

    task automatic test_inject();
        offer(8'hFF, 1'b1, 2'd1);
        drain("inj_sel1");
        offer(8'hFF, 1'b1, 2'd3);
        drain("inj_sel3");
        offer(8'h5A, 1'b1, 2'd0);
        offer(8'hC3, 1'b1, 2'd2);
        drain("inj_sel0_sel2");
    endtask

    task automatic test_stall();
        offer(8'h96, 1'b1, 2'd2);
        in_valid = 1'b1; in_data = 8'h3C; inj_en = 1'b0; inj_sel = 2'd0;
        repeat (5) @(negedge clk);
        in_data = 8'h81;
        offer(8'h6E, 1'b0, 2'd0);
        drain("stall");
    endtask

    task automatic test_reset_mid_frame();
        offer(8'h5A, 1'b0, 2'd0);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (tx_valid !== 1'b0 || tx_bit !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_frame got tx_valid=%b tx_bit=%b in_ready=%b, required 0 0 0",
                     tx_valid, tx_bit, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_release got in_ready=%b tx_valid=%b, required 1 0", in_ready, tx_valid);
        end
        offer(8'h3C, 1'b0, 2'd0);
        drain("after_reset");
    endtask

`ifdef REP3_PARITY_EN
    task automatic test_parity();
        offer(8'h07, 1'b0, 2'd0);
        drain("parity_07");
        offer(8'h03, 1'b0, 2'd0);
        drain("parity_03");
        offer(8'h01, 1'b1, 2'd2);
        drain("parity_inj");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_inject();
        test_stall();
        test_reset_mid_frame();
`ifdef REP3_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
